year_bcd_sequencer: RTL
=======================

// Module: year_bcd_sequencer
// PURPOSE
//  Start/busy/done sequencer that converts a binary year into four BCD digits
//  by iterative subtraction of 1000, 100 and 10. It uses one shared
//  subtractor/comparator, with no dividers.
//  Sits between the calendar year counter and the 7-segment digit mux.
//  Outputs change only at completion, so the display never shows a partial
//  result.
// PARAMETERS
//  YEAR_W   11   width of binary year input; legal range 4..13 (thousands <= 8)
// PORTS
//  clk      in   1       system clock, all state on rising edge
//  rst      in   1       asynchronous, active-high reset
//  start    in   1       request conversion of year_in; sampled only in IDLE
//  year_in  in   YEAR_W  binary year, captured on the accepted start edge
//  busy     out  1       high from the accepting edge until the DONE state ends
//  done     out  1       one-cycle pulse: digit outputs are valid and new
//  thous    out  4       BCD thousands digit
//  hundr    out  4       BCD hundreds digit
//  tens     out  4       BCD tens digit
//  units    out  4       BCD units digit
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy=0, done=0; all four digits=0;
//   internal remainder and counters cleared. Reset mid-conversion abandons it.
//  Internal: rem (YEAR_W bits) and cnt (4 bits); single comparator/subtractor
//   against weight W, where W = 1000 / 100 / 10 per state.
//  FSM (one transition per clk edge):
//   IDLE : start=1 -> rem<=year_in, cnt<=0, busy<=1, go THOU; else stay.
//   THOU : rem>=1000 -> rem-=1000, cnt++, stay.
//          Else thous_r<=cnt, cnt<=0, go HUND.
//   HUND : same with 100 -> hundr_r, go TENS.
//   TENS : same with 10.
//          On exit: tens_r<=cnt, units_r<=rem[3:0].
//          Load all four output digits from the staging regs in the same edge.
//          done<=1, go DONE.
//   DONE : done<=0, busy<=0, go IDLE.
//  Digit outputs update only on the TENS->DONE edge and otherwise hold.
//   Between conversions they keep the last result.
//  done is high for exactly the one cycle spent in DONE.
//  Latency: start edge to done high = th + h + t + 4 clk edges
//   (th, h, t = resulting thousands, hundreds, tens digits).
//   year 0 -> 4 edges. YEAR_W=11 worst case is 1999 -> 23 edges.
//  start while busy (THOU..DONE) is ignored, not queued.
//   A start seen in IDLE on the cycle after DONE is accepted normally, so
//   back-to-back conversions are allowed.
//  year_in changing after the accepting edge has no effect.
//  The comparator is unsigned and full YEAR_W width.
//   rem never underflows, because a subtract happens only when rem >= W.
//  Each cnt is at most 9, except thous, which is at most 8 by the YEAR_W
//   limit. No saturation logic is required.
// TESTING
//  1 Reset: assert rst mid-THOU -> immediately busy=0, done=0, all digits 0,
//    state IDLE.
//  2 year_in=2024, start pulse -> done after 8 edges;
//    thous=2, hundr=0, tens=2, units=4.
//  3 year_in=0 -> done after 4 edges, all digits 0.
//    Then year_in=1999 -> done after 23 edges; digits 1,9,9,9.
//  4 year_in=2047 -> 10 edges, digits 2,0,4,7.
//    Start held high throughout -> exactly one done per conversion.
//    Next conversion begins the cycle after done.
//  5 Start year 1987; pulse start=1 with year_in=2000 while busy ->
//    ignored, result 1,9,8,7.
//    Digits held until the next done, including while the next conversion
//    is busy.
//  6 Random sweep 0..2047 vs golden model:
//    digits match year/1000, (year%1000)/100, (year%100)/10 and year%10.
//    Measured latency equals th+h+t+4 on every conversion.

Source files
------------

// File: rtl/year_bcd_sequencer.sv
// Binary-year to four-digit BCD converter using repeated subtraction of 1000/100/10
// through one shared comparator/subtractor; digit outputs change only when a conversion completes.
module year_bcd_sequencer #(
    parameter int YEAR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [YEAR_W-1:0] year_in,
    output logic              busy,
    output logic              done,
    output logic [3:0]        thous,
    output logic [3:0]        hundr,
    output logic [3:0]        tens,
    output logic [3:0]        units
);

    // Comparator is at least 10 bits wide so the weight 1000 fits for narrow years.
    localparam int CMP_W = (YEAR_W > 10) ? YEAR_W : 10;

    typedef enum logic [2:0] {
        IDLE,
        THOU,
        HUND,
        TENS,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [YEAR_W-1:0] rem, rem_n;
    logic [3:0]        cnt, cnt_n;
    logic [3:0]        thous_r, thous_r_n;
    logic [3:0]        hundr_r, hundr_r_n;
    logic              busy_n, done_n;
    logic [3:0]        thous_n, hundr_n, tens_n, units_n;

    logic [CMP_W-1:0]  weight;
    logic [CMP_W-1:0]  rem_ext;
    logic [CMP_W-1:0]  diff;
    logic              ge;

    always_comb begin
        unique case (state)
            THOU:    weight = CMP_W'(1000);
            HUND:    weight = CMP_W'(100);
            default: weight = CMP_W'(10);
        endcase
        rem_ext = CMP_W'(rem);
        ge      = (rem_ext >= weight);
        diff    = rem_ext - weight;
    end

    // NOTE: every signal assigned here gets its hold value first, so no path through the case infers a latch.
    always_comb begin
        state_n   = state;
        rem_n     = rem;
        cnt_n     = cnt;
        thous_r_n = thous_r;
        hundr_r_n = hundr_r;
        busy_n    = busy;
        done_n    = done;
        thous_n   = thous;
        hundr_n   = hundr;
        tens_n    = tens;
        units_n   = units;

        unique case (state)
            IDLE: begin
                if (start) begin
                    rem_n   = year_in;
                    cnt_n   = 4'd0;
                    busy_n  = 1'b1;
                    state_n = THOU;
                end
            end
            THOU, HUND, TENS: begin
                if (ge) begin
                    rem_n = diff[YEAR_W-1:0];
                    cnt_n = cnt + 4'd1;
                end else begin
                    cnt_n = 4'd0;
                    unique case (state)
                        THOU: begin
                            thous_r_n = cnt;
                            state_n   = HUND;
                        end
                        HUND: begin
                            hundr_r_n = cnt;
                            state_n   = TENS;
                        end
                        default: begin
                            // All four digits move to the outputs together.
                            thous_n = thous_r;
                            hundr_n = hundr_r;
                            tens_n  = cnt;
                            units_n = rem[3:0];
                            done_n  = 1'b1;
                            state_n = DONE;
                        end
                    endcase
                end
            end
            DONE: begin
                done_n  = 1'b0;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            rem     <= '0;
            cnt     <= 4'd0;
            thous_r <= 4'd0;
            hundr_r <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            thous   <= 4'd0;
            hundr   <= 4'd0;
            tens    <= 4'd0;
            units   <= 4'd0;
        end else begin
            state   <= state_n;
            rem     <= rem_n;
            cnt     <= cnt_n;
            thous_r <= thous_r_n;
            hundr_r <= hundr_r_n;
            busy    <= busy_n;
            done    <= done_n;
            thous   <= thous_n;
            hundr   <= hundr_n;
            tens    <= tens_n;
            units   <= units_n;
        end
    end

endmodule
